// File: rtl/press_classifier_if.sv
// Button-level input and classification outputs of press_classifier.
// The classifier connects through the slave modport; the button source and consumer use master.
interface press_classifier_if;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic hold;
    logic busy;

    modport master (
        output btn_level,
        input  short_press,
        input  long_press,
        input  double_press,
        input  hold,
        input  busy
    );

    modport slave (
        input  btn_level,
        output short_press,
        output long_press,
        output double_press,
        output hold,
        output busy
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies a debounced button into short, long and double presses.
// All outputs are registered, and pulses last exactly one cycle.
module press_classifier #(
    parameter int CNT_W      = 27,
    parameter int LONG_TIME  = 100000000,
    parameter int DOUBLE_GAP = 30000000
) (
    input  logic              clk,
    input  logic              reset,
    press_classifier_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESS1    = 3'd1;
    localparam logic [2:0] WAIT2     = 3'd2;
    localparam logic [2:0] PRESS2    = 3'd3;
    localparam logic [2:0] LONG_HELD = 3'd4;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             btn_prev;
    logic             rise, fall;
    logic             next_short, next_long, next_double;
    logic             short_q, long_q, double_q, hold_q, busy_q;

    assign rise = bus.btn_level & ~btn_prev;
    assign fall = ~bus.btn_level & btn_prev;

    // In PRESS2 and LONG_HELD the previous level is always 1, so fall is just the release.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_short  = 1'b0;
        next_long   = 1'b0;
        next_double = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = PRESS1;
                    next_cnt   = '0;
                end
            end
            PRESS1: begin
                if (bus.btn_level) begin
                    if (cnt == LONG_LAST) begin
                        next_long  = 1'b1;
                        next_state = LONG_HELD;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end else begin
                    next_state = WAIT2;
                    next_cnt   = '0;
                end
            end
            WAIT2: begin
                if (bus.btn_level) begin
                    next_state = PRESS2;
                end else if (cnt == GAP_LAST) begin
                    next_short = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    next_double = 1'b1;
                    next_state  = IDLE;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // btn_prev resets high so a button held through reset is not seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            btn_prev <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            btn_prev <= bus.btn_level;
            short_q  <= next_short;
            long_q   <= next_long;
            double_q <= next_double;
            hold_q   <= (next_state == LONG_HELD);
            busy_q   <= (next_state != IDLE);
        end
    end

    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = double_q;
    assign bus.hold         = hold_q;
    assign bus.busy         = busy_q;

endmodule
